// File: rtl/mult_arb_pkg.sv
// Shared definitions for the multiplier arbiter.
// Provides the operand/product widths, the FSM state encoding, the default
// watchdog limit and a one-hot decode helper used by the top level.
package mult_arb_pkg;

  localparam int OPW             = 8;   // operand width
  localparam int PW              = 16;  // product width
  localparam int TIMEOUT_DEFAULT = 15;  // WAIT cycles before abort
  localparam int MAXREQ          = 8;   // largest supported requester count
  localparam int IDW             = 3;   // width of a requester index

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_START = 2'b01,
    ST_WAIT  = 2'b10,
    ST_RESP  = 2'b11
  } state_t;

  // Decode a requester index into a MAXREQ-wide one-hot vector.
  function automatic logic [MAXREQ-1:0] id_onehot(input logic [IDW-1:0] id);
    logic [MAXREQ-1:0] v;
    v     = '0;
    v[id] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick.
// Ports:
//   i_req        requester levels
//   i_last_grant index granted most recently (search starts just after it)
//   o_any        at least one requester is active
//   o_pick       first active requester after i_last_grant, cyclically
module rr_arbiter
  import mult_arb_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDW-1:0]  i_last_grant,
  output logic            o_any,
  output logic [IDW-1:0]  o_pick
);

  localparam int SW = IDW + 1;

  // Requests widened to the full index range so any 3-bit index is legal.
  logic [MAXREQ-1:0] w_req8;
  assign w_req8 = MAXREQ'(i_req);

  // w_idx[gi] is the requester sitting gi+1 places after the last grant.
  logic [IDW-1:0] w_idx [NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_idx
      logic [SW-1:0] w_sum;
      assign w_sum      = {1'b0, i_last_grant} + SW'(gi + 1);
      // last_grant < NREQ, so a single wrap subtraction is enough
      assign w_idx[gi]  = (w_sum >= SW'(NREQ)) ? IDW'(w_sum - SW'(NREQ))
                                               : w_sum[IDW-1:0];
    end
  endgenerate

  // Scan farthest-first so the nearest active requester wins.
  always_comb begin
    o_any  = 1'b0;
    o_pick = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (w_req8[w_idx[k]]) begin
        o_any  = 1'b1;
        o_pick = w_idx[k];
      end
    end
  end

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin scheduler sharing one sequential 8x8 multiplier between NREQ
// requesters, with zero-operand bypass and a WAIT watchdog.
// Ports:
//   clk, reset_a            clock, synchronous active-high reset
//   req/req_a/req_b/req_ack request levels, packed operands, capture pulse
//   rsp_valid/rsp_ready     per-requester response handshake
//   rsp_product/rsp_err     response payload, err marks a timeout abort
//   mult_*                  launch/operands/completion of the multiplier
//   grant_id/state_out/busy current owner and FSM debug view
module mult_arbiter
  import mult_arb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic                clk,
  input  logic                reset_a,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ*OPW-1:0] req_a,
  input  logic [NREQ*OPW-1:0] req_b,
  output logic [NREQ-1:0]     req_ack,
  output logic [NREQ-1:0]     rsp_valid,
  input  logic [NREQ-1:0]     rsp_ready,
  output logic [PW-1:0]       rsp_product,
  output logic                rsp_err,
  output logic                mult_start,
  output logic [OPW-1:0]      mult_dataa,
  output logic [OPW-1:0]      mult_datab,
  input  logic                mult_done,
  input  logic [PW-1:0]       mult_product,
  output logic [IDW-1:0]      grant_id,
  output logic [1:0]          state_out,
  output logic                busy
);

  localparam int WDW = $clog2(TIMEOUT + 1);

  state_t            r_state;
  logic [IDW-1:0]    r_grant;
  logic [IDW-1:0]    r_last_grant;
  logic [OPW-1:0]    r_a;
  logic [OPW-1:0]    r_b;
  logic [PW-1:0]     r_product;
  logic              r_err;
  logic              r_start;
  logic [NREQ-1:0]   r_ack;
  logic [NREQ-1:0]   r_valid;
  logic [WDW-1:0]    r_wdog;

  logic              w_any;
  logic [IDW-1:0]    w_pick;
  logic [OPW-1:0]    w_a [MAXREQ];
  logic [OPW-1:0]    w_b [MAXREQ];
  logic [MAXREQ-1:0] w_ready8;
  logic [MAXREQ-1:0] w_pick_1h8;
  logic [MAXREQ-1:0] w_grant_1h8;
  logic [OPW-1:0]    w_pick_a;
  logic [OPW-1:0]    w_pick_b;
  logic              w_timeout;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .i_req        (req),
    .i_last_grant (r_last_grant),
    .o_any        (w_any),
    .o_pick       (w_pick)
  );

  // Unpack operands into an index-addressable view; unused slots read 0.
  genvar gi;
  generate
    for (gi = 0; gi < MAXREQ; gi++) begin : g_ops
      if (gi < NREQ) begin : g_used
        assign w_a[gi] = req_a[gi*OPW +: OPW];
        assign w_b[gi] = req_b[gi*OPW +: OPW];
      end else begin : g_unused
        assign w_a[gi] = '0;
        assign w_b[gi] = '0;
      end
    end
  endgenerate

  assign w_ready8    = MAXREQ'(rsp_ready);
  assign w_pick_1h8  = id_onehot(w_pick);
  assign w_grant_1h8 = id_onehot(r_grant);
  assign w_pick_a    = w_a[w_pick];
  assign w_pick_b    = w_b[w_pick];
  // The counter holds the number of WAIT cycles already spent, so the
  // TIMEOUT-th WAIT cycle is the last one.
  assign w_timeout   = (r_wdog == WDW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset_a) begin
      r_state      <= ST_IDLE;
      r_grant      <= '0;
      r_last_grant <= IDW'(NREQ - 1);
      r_a          <= '0;
      r_b          <= '0;
      r_product    <= '0;
      r_err        <= 1'b0;
      r_start      <= 1'b0;
      r_ack        <= '0;
      r_valid      <= '0;
      r_wdog       <= '0;
    end else begin
      r_ack   <= '0;
      r_start <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_grant <= w_pick;
            r_a     <= w_pick_a;
            r_b     <= w_pick_b;
            r_ack   <= w_pick_1h8[NREQ-1:0];
            if (w_pick_a == '0 || w_pick_b == '0) begin
              // Product is trivially zero: skip the multiplier entirely.
              r_product <= '0;
              r_err     <= 1'b0;
              r_valid   <= w_pick_1h8[NREQ-1:0];
              r_state   <= ST_RESP;
            end else begin
              r_start <= 1'b1;
              r_state <= ST_START;
            end
          end
        end
        ST_START: begin
          r_wdog  <= '0;
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          // Completion takes precedence over a coincident timeout.
          if (mult_done) begin
            r_product <= mult_product;
            r_err     <= 1'b0;
            r_valid   <= w_grant_1h8[NREQ-1:0];
            r_state   <= ST_RESP;
          end else if (w_timeout) begin
            r_product <= '0;
            r_err     <= 1'b1;
            r_valid   <= w_grant_1h8[NREQ-1:0];
            r_state   <= ST_RESP;
          end else begin
            r_wdog <= r_wdog + WDW'(1);
          end
        end
        ST_RESP: begin
          // Only the owner's ready completes the handshake.
          if (w_ready8[r_grant]) begin
            r_valid      <= '0;
            r_last_grant <= r_grant;
            r_state      <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign req_ack     = r_ack;
  assign rsp_valid   = r_valid;
  assign rsp_product = r_product;
  assign rsp_err     = r_err;
  assign mult_start  = r_start;
  assign mult_dataa  = r_a;
  assign mult_datab  = r_b;
  assign grant_id    = r_grant;
  assign state_out   = r_state;
  assign busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed testbench for mult_arbiter with a 4-cycle multiplier model.
module tb_mult_arbiter;

  logic        clk = 1'b0;
  logic        reset_a = 1'b1;
  logic [3:0]  req = '0;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic [3:0]  req_ack;
  logic [3:0]  rsp_valid;
  logic [3:0]  rsp_ready = '0;
  logic [15:0] rsp_product;
  logic        rsp_err;
  logic        mult_start;
  logic [7:0]  mult_dataa;
  logic [7:0]  mult_datab;
  logic        mult_done;
  logic [15:0] mult_product;
  logic [2:0]  grant_id;
  logic [1:0]  state_out;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Multiplier model: done four cycles after the start pulse.
  logic        mult_en = 1'b1;
  int          m_cnt = 0;
  logic        m_done = 1'b0;
  logic [15:0] m_prod = '0;
  logic [15:0] m_hold = '0;
  logic        stray_done = 1'b0;
  logic [15:0] stray_prod = '0;

  assign mult_done    = m_done | stray_done;
  assign mult_product = stray_done ? stray_prod : m_prod;

  always #5 clk = ~clk;

  always @(negedge clk) begin
    m_done = 1'b0;
    if (mult_start) begin
      m_cnt  = 4;
      m_hold = mult_dataa * mult_datab;
    end else if (m_cnt > 0) begin
      m_cnt = m_cnt - 1;
      if (m_cnt == 0 && mult_en) begin
        m_done = 1'b1;
        m_prod = m_hold;
      end
    end
  end

  mult_arbiter #(.NREQ(4), .TIMEOUT(15)) dut (
    .clk          (clk),
    .reset_a      (reset_a),
    .req          (req),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_ack      (req_ack),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_product  (rsp_product),
    .rsp_err      (rsp_err),
    .mult_start   (mult_start),
    .mult_dataa   (mult_dataa),
    .mult_datab   (mult_datab),
    .mult_done    (mult_done),
    .mult_product (mult_product),
    .grant_id     (grant_id),
    .state_out    (state_out),
    .busy         (busy)
  );

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  // Waits (bounded) for any rsp_valid; returns cycles waited, 0 on expiry.
  task automatic wait_rsp(input int limit, output int waited);
    waited = 0;
    for (int n = 1; n <= limit; n++) begin
      tick();
      if (rsp_valid != 4'b0000) begin
        waited = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset_a = 1'b1;
    tick();
    tick();
    checks++;
    if ({state_out, grant_id, busy, req_ack, rsp_valid, mult_start, rsp_err} !== 15'd0) begin
      errors++;
      $display("FAIL reset_ctrl: state=%0d grant=%0d busy=%b ack=%b valid=%b start=%b err=%b, required all 0",
               state_out, grant_id, busy, req_ack, rsp_valid, mult_start, rsp_err);
    end
    checks++;
    if ({rsp_product, mult_dataa, mult_datab} !== 32'd0) begin
      errors++;
      $display("FAIL reset_data: product=%h a=%h b=%h, required 0", rsp_product, mult_dataa, mult_datab);
    end
    reset_a = 1'b0;
    $display("reset: state=%0d grant=%0d", state_out, grant_id);
  endtask

  task automatic test_single();
    int w;
    int starts;
    req = 4'b0001;
    req_a[7:0] = 8'd12;
    req_b[7:0] = 8'd13;
    tick();
    checks++;
    if (req_ack !== 4'b0001 || mult_start !== 1'b1 || state_out !== 2'd1) begin
      errors++;
      $display("FAIL single_launch: ack=%b start=%b state=%0d, required 0001 1 1", req_ack, mult_start, state_out);
    end
    checks++;
    if (mult_dataa !== 8'd12 || mult_datab !== 8'd13 || grant_id !== 3'd0) begin
      errors++;
      $display("FAIL single_ops: a=%0d b=%0d grant=%0d, required 12 13 0", mult_dataa, mult_datab, grant_id);
    end
    req = 4'b0000;
    starts = 0;
    w = 0;
    for (int n = 1; n <= 30; n++) begin
      tick();
      if (mult_start) starts++;
      if (rsp_valid != 4'b0000) begin
        w = n;
        break;
      end
    end
    checks++;
    if (w !== 5 || starts !== 0) begin
      errors++;
      $display("FAIL single_latency: rsp after %0d cycles with %0d extra starts, required 5 and 0", w, starts);
    end
    checks++;
    if (rsp_valid !== 4'b0001 || rsp_product !== 16'd156 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL single_rsp: valid=%b product=%0d err=%b, required 0001 156 0", rsp_valid, rsp_product, rsp_err);
    end
    $display("single: req0 12*13 -> product=%0d err=%b", rsp_product, rsp_err);
    rsp_ready = 4'b0001;
    tick();
    checks++;
    if (state_out !== 2'd0 || rsp_valid !== 4'b0000) begin
      errors++;
      $display("FAIL single_accept: state=%0d valid=%b, required 0 0000", state_out, rsp_valid);
    end
    rsp_ready = 4'b0000;
  endtask

  task automatic test_round_robin();
    int          exp_id [5] = '{0, 1, 2, 3, 0};
    logic [15:0] exp_p  [4] = '{16'd21, 16'h4E20, 16'd255, 16'hFE01};
    logic [3:0]  exp_1h;
    int          last_ack;
    int          w;
    bit          found;
    // restart so requester 0 has first priority again
    reset_a = 1'b1;
    tick();
    reset_a = 1'b0;
    req_a = {8'd255, 8'd17, 8'd100, 8'd3};
    req_b = {8'd255, 8'd15, 8'd200, 8'd7};
    rsp_ready = 4'b1111;
    req = 4'b1111;
    last_ack = 0;
    for (int g = 0; g < 5; g++) begin
      exp_1h = 4'(1 << exp_id[g]);
      found = 0;
      for (int n = 0; n < 20; n++) begin
        tick();
        if (req_ack != 4'b0000) begin
          found = 1;
          break;
        end
      end
      checks++;
      if (!found) begin
        errors++;
        $display("FAIL rr_ack%0d: no req_ack within 20 cycles, required %b", g, exp_1h);
      end else begin
        checks++;
        if (req_ack !== exp_1h || grant_id !== 3'(exp_id[g])) begin
          errors++;
          $display("FAIL rr_order%0d: ack=%b grant=%0d, required %b %0d", g, req_ack, grant_id, exp_1h, exp_id[g]);
        end
        if (g > 0) begin
          checks++;
          if (cyc - last_ack !== 7) begin
            errors++;
            $display("FAIL rr_spacing%0d: %0d cycles between grants, required 7", g, cyc - last_ack);
          end
        end
        last_ack = cyc;
        wait_rsp(20, w);
        if (g == 4) req = 4'b0000;
        checks++;
        if (rsp_valid !== exp_1h || rsp_product !== exp_p[exp_id[g]] || rsp_err !== 1'b0) begin
          errors++;
          $display("FAIL rr_rsp%0d: valid=%b product=%h err=%b, required %b %h 0",
                   g, rsp_valid, rsp_product, rsp_err, exp_1h, exp_p[exp_id[g]]);
        end
        $display("round_robin: grant %0d -> req%0d product=%h", g, exp_id[g], rsp_product);
      end
    end
    req = 4'b0000;
    tick();
    rsp_ready = 4'b0000;
    tick();
  endtask

  task automatic test_zero_bypass();
    req_a[23:16] = 8'h00;
    req_b[23:16] = 8'hAA;
    req = 4'b0100;
    tick();
    checks++;
    if (req_ack !== 4'b0100 || rsp_valid !== 4'b0100 || mult_start !== 1'b0 || state_out !== 2'd3) begin
      errors++;
      $display("FAIL bypass_rsp: ack=%b valid=%b start=%b state=%0d, required 0100 0100 0 3",
               req_ack, rsp_valid, mult_start, state_out);
    end
    checks++;
    if (rsp_product !== 16'd0 || rsp_err !== 1'b0 || grant_id !== 3'd2) begin
      errors++;
      $display("FAIL bypass_data: product=%h err=%b grant=%0d, required 0000 0 2", rsp_product, rsp_err, grant_id);
    end
    $display("zero_bypass: req2 0*AA -> product=%h", rsp_product);
    req = 4'b0000;
    rsp_ready = 4'b0100;
    tick();
    checks++;
    if (state_out !== 2'd0 || mult_start !== 1'b0) begin
      errors++;
      $display("FAIL bypass_done: state=%0d start=%b, required 0 0", state_out, mult_start);
    end
    rsp_ready = 4'b0000;
  endtask

  task automatic test_backpressure();
    int w;
    req_a[15:8] = 8'd9;
    req_b[15:8] = 8'd11;
    req = 4'b0010;
    tick();
    checks++;
    if (req_ack !== 4'b0010) begin
      errors++;
      $display("FAIL bp_ack: ack=%b, required 0010", req_ack);
    end
    req = 4'b0001;
    req_a[7:0] = 8'd2;
    req_b[7:0] = 8'd2;
    rsp_ready = 4'b1101;  // everyone but the owner is ready
    wait_rsp(20, w);
    checks++;
    if (rsp_valid !== 4'b0010 || rsp_product !== 16'd99) begin
      errors++;
      $display("FAIL bp_rsp: valid=%b product=%0d, required 0010 99", rsp_valid, rsp_product);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (rsp_valid !== 4'b0010 || rsp_product !== 16'd99 || req_ack !== 4'b0000 || state_out !== 2'd3) begin
        errors++;
        $display("FAIL bp_hold%0d: valid=%b product=%0d ack=%b state=%0d, required 0010 99 0000 3",
                 i, rsp_valid, rsp_product, req_ack, state_out);
      end
    end
    $display("backpressure: req1 held %0d for 10 cycles", rsp_product);
    rsp_ready = 4'b1111;
    tick();
    checks++;
    if (rsp_valid !== 4'b0000 || state_out !== 2'd0) begin
      errors++;
      $display("FAIL bp_release: valid=%b state=%0d, required 0000 0", rsp_valid, state_out);
    end
    tick();
    checks++;
    if (req_ack !== 4'b0001) begin
      errors++;
      $display("FAIL bp_next_grant: ack=%b, required 0001", req_ack);
    end
    req = 4'b0000;
    wait_rsp(20, w);
    checks++;
    if (rsp_valid !== 4'b0001 || rsp_product !== 16'd4) begin
      errors++;
      $display("FAIL bp_next_rsp: valid=%b product=%0d, required 0001 4", rsp_valid, rsp_product);
    end
    $display("backpressure: req0 2*2 -> product=%0d", rsp_product);
    tick();
    rsp_ready = 4'b0000;
  endtask

  task automatic test_timeout();
    int w;
    mult_en = 1'b0;
    req_a[15:8] = 8'd5;
    req_b[15:8] = 8'd6;
    req = 4'b0010;
    tick();
    checks++;
    if (req_ack !== 4'b0010 || mult_start !== 1'b1) begin
      errors++;
      $display("FAIL to_launch: ack=%b start=%b, required 0010 1", req_ack, mult_start);
    end
    req = 4'b0000;
    wait_rsp(40, w);
    checks++;
    if (w !== 16) begin
      errors++;
      $display("FAIL to_latency: RESP %0d cycles after START, required 16", w);
    end
    checks++;
    if (rsp_valid !== 4'b0010 || rsp_product !== 16'd0 || rsp_err !== 1'b1) begin
      errors++;
      $display("FAIL to_rsp: valid=%b product=%h err=%b, required 0010 0000 1", rsp_valid, rsp_product, rsp_err);
    end
    $display("timeout: req1 aborted after %0d cycles err=%b", w, rsp_err);
    stray_prod = 16'h1234;
    stray_done = 1'b1;
    tick();
    stray_done = 1'b0;
    checks++;
    if (rsp_product !== 16'd0 || rsp_err !== 1'b1 || state_out !== 2'd3 || rsp_valid !== 4'b0010) begin
      errors++;
      $display("FAIL to_stray_resp: product=%h err=%b state=%0d valid=%b, required 0000 1 3 0010",
               rsp_product, rsp_err, state_out, rsp_valid);
    end
    rsp_ready = 4'b0010;
    tick();
    rsp_ready = 4'b0000;
    stray_done = 1'b1;
    tick();
    stray_done = 1'b0;
    tick();
    checks++;
    if (state_out !== 2'd0 || rsp_valid !== 4'b0000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL to_stray_idle: state=%0d valid=%b busy=%b, required 0 0000 0", state_out, rsp_valid, busy);
    end
    mult_en = 1'b1;
  endtask

  task automatic test_reset_midop();
    int w;
    req_a[31:24] = 8'd10;
    req_b[31:24] = 8'd10;
    req_a[7:0] = 8'd6;
    req_b[7:0] = 8'd7;
    req = 4'b1000;
    tick();
    checks++;
    if (req_ack !== 4'b1000 || grant_id !== 3'd3) begin
      errors++;
      $display("FAIL mid_ack: ack=%b grant=%0d, required 1000 3", req_ack, grant_id);
    end
    tick();
    checks++;
    if (state_out !== 2'd2) begin
      errors++;
      $display("FAIL mid_wait: state=%0d, required 2", state_out);
    end
    reset_a = 1'b1;
    req = 4'b1001;
    tick();
    checks++;
    if (state_out !== 2'd0 || rsp_valid !== 4'b0000 || busy !== 1'b0 || mult_start !== 1'b0 || grant_id !== 3'd0) begin
      errors++;
      $display("FAIL mid_reset: state=%0d valid=%b busy=%b start=%b grant=%0d, required 0 0000 0 0 0",
               state_out, rsp_valid, busy, mult_start, grant_id);
    end
    reset_a = 1'b0;
    tick();
    checks++;
    if (req_ack !== 4'b0001 || grant_id !== 3'd0) begin
      errors++;
      $display("FAIL mid_first_grant: ack=%b grant=%0d, required 0001 0", req_ack, grant_id);
    end
    req = 4'b0000;
    wait_rsp(20, w);
    checks++;
    if (rsp_valid !== 4'b0001 || rsp_product !== 16'd42) begin
      errors++;
      $display("FAIL mid_rsp: valid=%b product=%0d, required 0001 42", rsp_valid, rsp_product);
    end
    $display("reset_midop: first grant after reset req0 product=%0d", rsp_product);
    rsp_ready = 4'b0001;
    tick();
    rsp_ready = 4'b0000;
  endtask

  initial begin
    tick();
    test_reset();
    test_single();
    test_round_robin();
    test_zero_bypass();
    test_backpressure();
    test_timeout();
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded 200000 time units, required completion");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/mult_arbiter.md
# mult_arbiter

Round-robin scheduler that shares one sequential 8x8 multiplier (the `mult_control`-sequenced datapath) between `NREQ` requesters. It captures one requester's operands per transaction and launches the multiplier. It waits for `done`, then returns the 16-bit product to the owning requester over a valid/ready response handshake. Zero operands bypass the multiplier. A watchdog guards against a hung multiplier.

## Interface
Parameters:
- `NREQ`, 4, number of requesters (2..8)
- `TIMEOUT`, 15, max WAIT cycles before aborting a multiplication (must be >= 5)

Ports:
- `clk`  in  1  single clock, rising edge
- `reset_a`  in  1  synchronous, active-high reset
- `req`  in  NREQ  per-requester request level
- `req_a`  in  NREQ*8  packed operand A, requester i at [8i+7:8i]
- `req_b`  in  NREQ*8  packed operand B, same packing
- `req_ack`  out  NREQ  one-cycle pulse: operands of requester i captured
- `rsp_valid`  out  NREQ  product available for requester i (one-hot or zero)
- `rsp_ready`  in  NREQ  requester i accepts product
- `rsp_product`  out  16  product for the requester whose `rsp_valid` is high
- `rsp_err`  out  1  qualifies `rsp_product`: transaction aborted by timeout
- `mult_start`  out  1  one-cycle launch pulse to multiplier
- `mult_dataa`, `mult_datab`  out  8 each  captured operands, stable START through WAIT
- `mult_done`  in  1  multiplier completion
- `mult_product`  in  16  multiplier result, valid with `mult_done`
- `grant_id`  out  3  index of current owner
- `state_out`  out  2  FSM state, debug
- `busy`  out  1  state != IDLE

## Operation
- FSM states: IDLE=00, START=01, WAIT=10, RESP=11.
- IDLE, any `req` high:
  - Pick the first requester after `last_grant`, cyclically.
  - Capture its operands and set `grant_id`.
  - If either operand is 0: product=0, go to RESP.
  - Otherwise go to START.
- START: `mult_start`=1 for exactly this cycle; go to WAIT; clear watchdog.
- WAIT:
  - On `mult_done`: capture `mult_product`, `rsp_err`=0, go to RESP.
  - Else, watchdog reaches `TIMEOUT`: product=16'h0000, `rsp_err`=1, go to RESP.
  - `mult_done` wins if it coincides with the timeout.
- RESP:
  - `rsp_valid[grant_id]`=1 with product held stable until `rsp_ready[grant_id]`.
  - On acceptance go to IDLE; `last_grant`<=`grant_id`.
  - `rsp_ready` of other requesters is ignored.
- `req_ack[i]` pulses in the cycle after the grant decision, i.e. the first cycle of START or RESP.
- `req` still high after the ack is a new request. It competes in the next IDLE arbitration.
- `mult_done` outside WAIT is ignored.
- No back-to-back overlap: one transaction in flight at a time.
- Reset values:
  - All outputs 0 (`state_out`=IDLE, `grant_id`=0).
  - `last_grant`=NREQ-1, so requester 0 has first priority.
- Reset mid-operation: return to IDLE next edge; the in-flight transaction is dropped with no response; `mult_start` is not reissued.

## Timing
- Cycle t: IDLE samples `req`.
- Cycle t+1: START; `req_ack` and `mult_start` high.
- With the 4-cycle multiplier, `mult_done` arrives at t+5.
- RESP at t+6 with `rsp_valid` high.
- Earliest next grant: IDLE at t+7 if `rsp_ready` is high at t+6. Minimum 7 cycles per transaction.
- Zero bypass: RESP at t+1, ack in the same cycle; 2 cycles per transaction.
- Timeout: RESP at t+2+`TIMEOUT`.
- `rsp_valid` may stay high indefinitely; the arbiter stalls and `req` levels are ignored until acceptance.

## Structure
- Package `mult_arb_pkg`:
  - State encoding localparams (IDLE/START/WAIT/RESP).
  - Widths OPW=8, PW=16.
  - Default TIMEOUT.
- Sub-module `rr_arbiter` (purely combinational): inputs `req` vector and `last_grant`; outputs `any`, `pick` index.
- Top holds the FSM, operand/product registers, watchdog counter and response muxing.

## Test plan
- Single request: req[0]=1, a=8'd12, b=8'd13, multiplier model done at t+5 → ack[0] at t+1, `mult_start` once, rsp_valid[0] with product 16'd156, `rsp_err`=0.
- All four requesting continuously, rsp_ready tied high → grants in order 0,1,2,3,0; each gets its own product (e.g. 255*255=16'hFE01 on requester 3).
- Zero bypass: req[2]=1, a=0, b=8'hAA → no `mult_start`; rsp_valid[2] at t+1 with product 0.
- Back-pressure: rsp_ready[1]=0 for 10 cycles while req[0]=1 → rsp_valid[1] and product held stable; no new grant until rsp_ready[1]=1.
- Timeout: multiplier never asserts done, TIMEOUT=15 → RESP at t+17, product 0, `rsp_err`=1; a stray late `mult_done` is ignored.
- Reset asserted in WAIT → IDLE next cycle, no rsp_valid; first grant after reset goes to requester 0 even if req[3] is also high.
